// File: rtl/uart_baud_gen.sv
// Dual-channel UART baud generator: shared runtime divisor, independent Tx/Rx
// prescalers with xOVERSAMPLE tick counters, Tx bit strobe/clock and Rx mid-bit sampling.
module uart_baud_gen #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    input  logic             tx_en,
    input  logic             rx_en,
    input  logic             rx_restart,
    output logic             div_pending,
    output logic             tx_tick,
    output logic             tx_bclk,
    output logic             rx_os_tick,
    output logic             rx_sample,
    output logic             rx_bit_end
);

    localparam int unsigned      OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] r_div_active;
    logic [DIV_W-1:0] r_div_shadow;
    logic             r_div_pending;

    logic [DIV_W-1:0] r_pc_tx;
    logic [OS_W-1:0]  r_os_tx;
    logic             r_tx_bclk;

    logic [DIV_W-1:0] r_pc_rx;
    logic [OS_W-1:0]  r_os_rx;

    logic w_tx_os;
    logic w_rx_os;
    logic w_rx_restart;
    logic w_div_apply;

    assign w_tx_os      = tx_en & (r_pc_tx == r_div_active);
    assign w_rx_restart = rx_en & rx_restart;
    // A restart cycle never produces an Rx tick, even if the prescaler matches.
    assign w_rx_os      = rx_en & ~rx_restart & (r_pc_rx == r_div_active);
    // Divisor only swaps while both channels idle, so no bit is ever stretched.
    assign w_div_apply  = r_div_pending & ~tx_en & ~rx_en;

    assign div_pending = r_div_pending;
    assign tx_tick     = w_tx_os & (r_os_tx == OS_LAST);
    assign tx_bclk     = r_tx_bclk;
    assign rx_os_tick  = w_rx_os;
    assign rx_sample   = w_rx_os & (r_os_rx == OS_MID);
    assign rx_bit_end  = w_rx_os & (r_os_rx == OS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_active  <= DIV_RST;
            r_div_shadow  <= DIV_RST;
            r_div_pending <= 1'b0;
        end else begin
            if (w_div_apply) begin
                r_div_active <= r_div_shadow;
            end
            if (div_load) begin
                r_div_shadow  <= div_in;
                r_div_pending <= 1'b1;
            end else if (w_div_apply) begin
                r_div_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_tx <= '0;
            r_os_tx <= '0;
        end else if (!tx_en) begin
            r_pc_tx <= '0;
            r_os_tx <= '0;
        end else if (w_tx_os) begin
            r_pc_tx <= '0;
            r_os_tx <= (r_os_tx == OS_LAST) ? '0 : r_os_tx + OS_W'(1);
        end else begin
            r_pc_tx <= r_pc_tx + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_bclk <= 1'b0;
        end else if (tx_tick) begin
            r_tx_bclk <= ~r_tx_bclk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_rx <= '0;
            r_os_rx <= '0;
        end else if (!rx_en || w_rx_restart) begin
            r_pc_rx <= '0;
            r_os_rx <= '0;
        end else if (w_rx_os) begin
            r_pc_rx <= '0;
            r_os_rx <= (r_os_rx == OS_LAST) ? '0 : r_os_rx + OS_W'(1);
        end else begin
            r_pc_rx <= r_pc_rx + DIV_W'(1);
        end
    end

endmodule
